// File: rtl/xpb_pkg.sv
// Shared definitions for the xpb reduction accumulator: default operand width,
// FSM state encoding and width-derivation helpers.
package xpb_pkg;

    localparam int unsigned XPB_W_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        OUT
    } state_e;

    // Number of b-sized chunks needed to cover a.
    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Index width able to address n items (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// Bitwise 3:2 carry-save compressor. Outputs the unshifted majority; the
// caller applies the one-bit carry shift.
module csa_3to2 #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] maj_o
);

    // Per-bit full-adder sum and majority.
    always_comb begin
        sum_o = a_i ^ b_i ^ c_i;
        maj_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end

endmodule

// File: rtl/xpb_reduce_accum.sv
// Carry-save accumulator for xpb lookup values. Loads a base operand, folds in
// one lookup value per accepted beat, then resolves the redundant sum with a
// segmented carry-propagate pass and offers the result over valid/ready.
// Optional headroom monitor: define XPB_ACC_OVF_CHECK_EN to add overflow_o.
module xpb_reduce_accum
    import xpb_pkg::*;
#(
    parameter int unsigned XPB_W = XPB_W_DEF,
    parameter int unsigned ACC_W = XPB_W + 16,
    parameter int unsigned SEG_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [XPB_W-1:0] base_i,
    input  logic             xpb_valid_i,
    input  logic [XPB_W-1:0] xpb_data_i,
    input  logic             xpb_last_i,
    output logic             xpb_ready_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [ACC_W-1:0] res_data_o,
    output logic             busy_o
`ifdef XPB_ACC_OVF_CHECK_EN
    ,
    output logic             overflow_o
`endif
);

    localparam int unsigned NSEG   = ceil_div(ACC_W, SEG_W);
    localparam int unsigned SIDX_W = idx_w(NSEG);
    localparam logic [SIDX_W-1:0] SEG_LAST = SIDX_W'(NSEG - 1);

    state_e            state_q;
    logic [ACC_W-1:0]  sum_q;
    logic [ACC_W-1:0]  carry_q;
    logic [ACC_W-1:0]  res_q;
    logic [SIDX_W-1:0] seg_q;
    logic              cin_q;
    logic              xpb_ready_q;
    logic              res_valid_q;
    logic              busy_q;

    logic [ACC_W-1:0]  xpb_ext;
    logic [ACC_W-1:0]  csa_sum;
    logic [ACC_W-1:0]  csa_maj;
    logic [ACC_W-1:0]  carry_new;
    logic              beat_acc;

    logic [31:0]       seg_shift;
    logic [SEG_W-1:0]  sum_seg;
    logic [SEG_W-1:0]  carry_seg;
    logic [SEG_W:0]    seg_add;
    logic [ACC_W-1:0]  seg_mask;
    logic [ACC_W-1:0]  res_merge;

`ifdef XPB_ACC_OVF_CHECK_EN
    localparam int unsigned HEAD_W = ACC_W - XPB_W;
    localparam logic [HEAD_W:0] OVF_LIM = {1'b1, {HEAD_W{1'b0}}};

    logic [HEAD_W:0] cnt_q;
    logic [HEAD_W:0] cnt_nxt;
    logic            overflow_q;

    // Saturating beat count so a long stream cannot wrap the monitor.
    always_comb begin
        cnt_nxt = (&cnt_q) ? cnt_q : cnt_q + (HEAD_W + 1)'(1);
    end

    assign overflow_o = overflow_q;
`endif

    assign xpb_ext   = ACC_W'(xpb_data_i);
    assign beat_acc  = xpb_valid_i && xpb_ready_q;
    // Top majority bit falls off here; lossless while headroom holds.
    assign carry_new = csa_maj << 1;

    csa_3to2 #(
        .W (ACC_W)
    ) u_csa (
        .a_i   (sum_q),
        .b_i   (carry_q),
        .c_i   (xpb_ext),
        .sum_o (csa_sum),
        .maj_o (csa_maj)
    );

    // One SEG_W+1-bit adder over the selected segment; the final segment is
    // narrower, so bits shifted past ACC_W (including its carry-out) drop away.
    always_comb begin
        seg_shift = 32'(seg_q) * SEG_W;
        sum_seg   = SEG_W'(sum_q >> seg_shift);
        carry_seg = SEG_W'(carry_q >> seg_shift);
        seg_add   = {1'b0, sum_seg} + {1'b0, carry_seg} + {{SEG_W{1'b0}}, cin_q};
        seg_mask  = ACC_W'({SEG_W{1'b1}}) << seg_shift;
        res_merge = (res_q & ~seg_mask) | (ACC_W'(seg_add[SEG_W-1:0]) << seg_shift);
    end

    // Control FSM with registered handshake/status outputs and datapath state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            carry_q     <= '0;
            res_q       <= '0;
            seg_q       <= '0;
            cin_q       <= 1'b0;
            xpb_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef XPB_ACC_OVF_CHECK_EN
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        sum_q       <= ACC_W'(base_i);
                        carry_q     <= '0;
                        state_q     <= ACCUM;
                        xpb_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
`ifdef XPB_ACC_OVF_CHECK_EN
                        cnt_q       <= '0;
                        overflow_q  <= 1'b0;
`endif
                    end
                end
                ACCUM: begin
                    if (beat_acc) begin
                        sum_q   <= csa_sum;
                        carry_q <= carry_new;
`ifdef XPB_ACC_OVF_CHECK_EN
                        cnt_q   <= cnt_nxt;
                        if (cnt_nxt >= OVF_LIM) begin
                            overflow_q <= 1'b1;
                        end
`endif
                        if (xpb_last_i) begin
                            state_q     <= RESOLVE;
                            seg_q       <= '0;
                            cin_q       <= 1'b0;
                            xpb_ready_q <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    res_q <= res_merge;
                    cin_q <= seg_add[SEG_W];
                    if (seg_q == SEG_LAST) begin
                        seg_q       <= '0;
                        state_q     <= OUT;
                        res_valid_q <= 1'b1;
                    end else begin
                        seg_q <= seg_q + SIDX_W'(1);
                    end
                end
                OUT: begin
                    if (res_ready_i) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign xpb_ready_o = xpb_ready_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_xpb_reduce_accum.sv
// Self-checking bench for xpb_reduce_accum: directed vector table, hand-written
// handshake/reset corner cases and randomized reductions against a plain
// arithmetic reference sum. Extra overflow checks when XPB_ACC_OVF_CHECK_EN is set.
module tb_xpb_reduce_accum;

    localparam int XW = 1024;
    localparam int AW = 1040;
    localparam int NR = 17;

    logic          clk;
    logic          rst;
    logic          start;
    logic [XW-1:0] base;
    logic          xv;
    logic [XW-1:0] xd;
    logic          xl;
    logic          xr;
    logic          rv;
    logic          rr;
    logic [AW-1:0] rd;
    logic          busy;
`ifdef XPB_ACC_OVF_CHECK_EN
    logic          ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    xpb_reduce_accum #(
        .XPB_W (XW),
        .ACC_W (AW),
        .SEG_W (64)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .base_i      (base),
        .xpb_valid_i (xv),
        .xpb_data_i  (xd),
        .xpb_last_i  (xl),
        .xpb_ready_o (xr),
        .res_valid_o (rv),
        .res_ready_i (rr),
        .res_data_o  (rd),
        .busy_o      (busy)
`ifdef XPB_ACC_OVF_CHECK_EN
        ,
        .overflow_o  (ovf)
`endif
    );

`ifdef XPB_ACC_OVF_CHECK_EN
    localparam int OW = XW + 2;
    logic          o_start;
    logic          o_xv;
    logic [XW-1:0] o_xd;
    logic          o_xl;
    logic          o_xr;
    logic          o_rv;
    logic          o_rr;
    logic [OW-1:0] o_rd;
    logic          o_busy;
    logic          o_ovf;

    xpb_reduce_accum #(
        .XPB_W (XW),
        .ACC_W (OW),
        .SEG_W (64)
    ) u_ovf (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (o_start),
        .base_i      (o_xd),
        .xpb_valid_i (o_xv),
        .xpb_data_i  (o_xd),
        .xpb_last_i  (o_xl),
        .xpb_ready_o (o_xr),
        .res_valid_o (o_rv),
        .res_ready_i (o_rr),
        .res_data_o  (o_rd),
        .busy_o      (o_busy),
        .overflow_o  (o_ovf)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [XW-1:0] base;
        int            n;
        logic [XW-1:0] d0;
        logic [AW-1:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h", nm,
                     act[AW-1:AW-80], act[63:0], exp[AW-1:AW-80], exp[63:0]);
        end
    endtask

    function automatic logic [XW-1:0] rand_wide();
        logic [XW-1:0] v;
        for (int i = 0; i < XW / 32; i++) v[i*32 +: 32] = $urandom;
        if ($urandom_range(0, 3) == 0) v = '1;
        return v;
    endfunction

    // Reference: exact integer sum truncated to the accumulator width.
    function automatic logic [AW-1:0] ref_sum(input logic [XW-1:0] b, input logic [XW-1:0] q[$]);
        logic [AW-1:0] acc;
        acc = AW'(b);
        foreach (q[i]) acc = acc + AW'(q[i]);
        return acc;
    endfunction

    task automatic do_start(input logic [XW-1:0] b);
        start = 1'b1;
        base  = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [XW-1:0] d, input logic last, input int gap);
        int   guard;
        logic r;
        guard = 0;
        r     = 1'b0;
        xv    = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        xv = 1'b1;
        xd = d;
        xl = last;
        do begin
            @(negedge clk);
            r = xr;
            @(posedge clk); #1;
            guard++;
        end while (!r && guard < 50);
        if (!r) chk("beat_accept_timeout", AW'(r), AW'(1));
        xv = 1'b0;
        xl = 1'b0;
    endtask

    // Counts edges after the last accepted beat until res_valid is seen.
    task automatic wait_result(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 60) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (rv) break;
            @(posedge clk); #1;
            lat++;
        end
        if (!rv) chk("result_timeout", AW'(rv), AW'(1));
    endtask

    task automatic handshake(input string nm, input int delay);
        repeat (delay) begin @(posedge clk); #1; end
        rr = 1'b1;
        @(posedge clk); #1;
        rr = 1'b0;
        chk({nm, "_valid_drop"}, AW'(rv), AW'(0));
        chk({nm, "_idle"}, AW'(busy), AW'(0));
    endtask

    task automatic run(input string nm, input logic [XW-1:0] b, input logic [XW-1:0] q[$],
                       input int gapmax, input int rdelay, input logic [AW-1:0] exp);
        int   lat;
        logic bok;
        do_start(b);
        foreach (q[i]) send_beat(q[i], (i == q.size() - 1), $urandom_range(0, gapmax));
        wait_result(lat, bok);
        chk({nm, "_latency"}, AW'(lat), AW'(NR));
        chk({nm, "_busy"}, AW'(bok), AW'(1));
        chk({nm, "_data"}, rd, exp);
        handshake(nm, rdelay);
    endtask

    initial begin
        vec_t          vecs[5];
        logic [XW-1:0] ones;
        logic [XW-1:0] q[$];
        logic [AW-1:0] held;
        logic [AW-1:0] exp;
        int            lat;
        logic          bok;

        ones = '1;
        vecs[0].base = '0;   vecs[0].n = 1; vecs[0].d0 = XW'(1); vecs[0].exp = AW'(1);
        vecs[1].base = ones; vecs[1].n = 1; vecs[1].d0 = XW'(1); vecs[1].exp = AW'(1) << 1024;
        vecs[2].base = ones; vecs[2].n = 5; vecs[2].d0 = ones;
        vecs[2].exp  = (AW'(1) << 1026) + (AW'(1) << 1025) - AW'(6);
        vecs[3].base = {(XW/4){4'h5}}; vecs[3].n = 1; vecs[3].d0 = {(XW/4){4'hA}};
        vecs[3].exp  = (AW'(1) << 1024) - AW'(1);
        vecs[4].base = XW'(7); vecs[4].n = 3; vecs[4].d0 = XW'(256); vecs[4].exp = AW'(32'h307);

        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        xv    = 1'b0;
        xd    = '0;
        xl    = 1'b0;
        rr    = 1'b0;
`ifdef XPB_ACC_OVF_CHECK_EN
        o_start = 1'b0;
        o_xv    = 1'b0;
        o_xd    = '0;
        o_xl    = 1'b0;
        o_rr    = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values, and no beat acceptance while idle.
        chk("rst_xpb_ready", AW'(xr), AW'(0));
        chk("rst_res_valid", AW'(rv), AW'(0));
        chk("rst_busy", AW'(busy), AW'(0));
        chk("rst_res_data", rd, AW'(0));
`ifdef XPB_ACC_OVF_CHECK_EN
        chk("rst_overflow", AW'(ovf), AW'(0));
`endif
        xv = 1'b1;
        xd = XW'(9);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_no_ready", AW'(xr), AW'(0));
        chk("idle_no_busy", AW'(busy), AW'(0));
        xv = 1'b0;

        // Directed vector table, beats back-to-back.
        for (int v = 0; v < 5; v++) begin
            q = {};
            for (int i = 0; i < vecs[v].n; i++) q.push_back(vecs[v].d0);
            run($sformatf("vec%0d", v), vecs[v].base, q, 0, v % 3, vecs[v].exp);
        end

        // A beat presented together with start must be ignored.
        start = 1'b1;
        base  = XW'(100);
        xv    = 1'b1;
        xd    = XW'(55);
        xl    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_beat(XW'(7), 1'b1, 0);
        wait_result(lat, bok);
        chk("startbeat_data", rd, AW'(107));
        handshake("startbeat", 0);

        // Backpressure in OUT with start pulses that must not be queued.
        do_start(XW'(40));
        send_beat(XW'(2), 1'b1, 0);
        wait_result(lat, bok);
        held = rd;
        chk("bp_data", held, AW'(42));
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            base  = XW'(i + 1000);
            @(posedge clk); #1;
            chk("bp_valid_held", AW'(rv), AW'(1));
            chk("bp_data_stable", rd, held);
        end
        start = 1'b0;
        handshake("bp", 0);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_start_not_queued", AW'(busy), AW'(0));

        // Reset at segment 8 of the resolve pass.
        do_start(ones);
        send_beat(ones, 1'b1, 0);
        repeat (8) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("midrst_res_data", rd, AW'(0));
        chk("midrst_busy", AW'(busy), AW'(0));
        chk("midrst_valid", AW'(rv), AW'(0));
        chk("midrst_ready", AW'(xr), AW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        q = {};
        q.push_back(XW'(3));
        run("post_rst", XW'(5), q, 0, 1, AW'(8));

        // Randomized reductions with gaps and delayed result acceptance.
        for (int t = 0; t < 25; t++) begin
            logic [XW-1:0] b;
            int n;
            b = rand_wide();
            n = $urandom_range(1, 8);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(rand_wide());
            exp = ref_sum(b, q);
            run($sformatf("rnd%0d", t), b, q, 2, $urandom_range(0, 3), exp);
        end

`ifdef XPB_ACC_OVF_CHECK_EN
        // Two bits of headroom: base plus three full-scale beats is the limit.
        o_xd    = ones;
        o_start = 1'b1;
        @(posedge clk); #1;
        o_start = 1'b0;
        o_xv    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            o_xl = (i == 3);
            @(posedge clk); #1;
            if (i == 2) chk("ovf_at_limit", AW'(o_ovf), AW'(0));
        end
        o_xv = 1'b0;
        o_xl = 1'b0;
        chk("ovf_set", AW'(o_ovf), AW'(1));
        repeat (25) @(posedge clk);
        #1;
        chk("ovf_back_idle", AW'(o_busy), AW'(0));
        chk("ovf_sticky", AW'(o_ovf), AW'(1));
        o_start = 1'b1;
        @(posedge clk); #1;
        o_start = 1'b0;
        chk("ovf_cleared", AW'(o_ovf), AW'(0));
        chk("main_no_ovf", AW'(ovf), AW'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
